// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start bit, DATA_BITS data bits LSB first, optional
// even/odd parity and a parametrised stop period. `define UART_TX_BREAK_EN adds send_break.
module uart_tx_cfg #(
  parameter int DATA_BITS = 8,
  parameter int OS_TICKS  = 16,
  parameter int SB_TICKS  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DATA_BITS-1:0] tx_data_in,
  input  logic [1:0]           parity_mode,
`ifdef UART_TX_BREAK_EN
  input  logic                 send_break,
`endif
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done_tick
);
  localparam int SMAX = (OS_TICKS > SB_TICKS) ? OS_TICKS : SB_TICKS;
  localparam int SW   = (SMAX > 1) ? $clog2(SMAX) : 1;
  localparam int NW   = $clog2(DATA_BITS) + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [SW-1:0]        s_q, s_d;
  logic [NW-1:0]        n_q, n_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 pen_q, pen_d;
  logic                 tx_q, tx_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 os_end, sb_end;

`ifdef UART_TX_BREAK_EN
  // A break must hold the line low for at least one plain (no-parity) frame.
  localparam int FRAME_TICKS = OS_TICKS * (1 + DATA_BITS) + SB_TICKS;
  localparam int BW          = $clog2(FRAME_TICKS + 1);
  logic [BW-1:0] brk_q, brk_d;
  logic          in_brk_q, in_brk_d;
`endif

  function automatic logic calc_parity(input logic [DATA_BITS-1:0] d, input logic [1:0] m);
    return (^d) ^ (m == 2'b10);
  endfunction

  assign os_end = tick && (s_q == SW'(OS_TICKS - 1));
  assign sb_end = tick && (s_q == SW'(SB_TICKS - 1));

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      s_q      <= SW'(0);
      n_q      <= NW'(0);
      shift_q  <= {DATA_BITS{1'b0}};
      par_q    <= 1'b0;
      pen_q    <= 1'b0;
      tx_q     <= 1'b1;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef UART_TX_BREAK_EN
      brk_q    <= BW'(0);
      in_brk_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      n_q      <= n_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      pen_q    <= pen_d;
      tx_q     <= tx_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef UART_TX_BREAK_EN
      brk_q    <= brk_d;
      in_brk_q <= in_brk_d;
`endif
    end
  end

  // Next-state and datapath logic
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    shift_d = shift_q;
    par_d   = par_q;
    pen_d   = pen_q;
    done_d  = 1'b0;
`ifdef UART_TX_BREAK_EN
    brk_d    = brk_q;
    in_brk_d = in_brk_q;
`endif
    case (state_q)
      S_IDLE: begin
`ifdef UART_TX_BREAK_EN
        if (send_break) begin
          state_d  = S_BREAK;
          brk_d    = BW'(0);
          in_brk_d = 1'b1;
        end else
`endif
        if (tx_valid && ready_q) begin
          state_d = S_START;
          s_d     = SW'(0);
          n_d     = NW'(0);
          shift_d = tx_data_in;
          par_d   = calc_parity(tx_data_in, parity_mode);
          pen_d   = (parity_mode == 2'b01) || (parity_mode == 2'b10);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (os_end) begin
          s_d     = SW'(0);
          state_d = S_DATA;
        end else if (tick) begin
          s_d = s_q + SW'(1);
        end else begin
          s_d = s_q;
        end
      end
      S_DATA: begin
        if (os_end) begin
          s_d     = SW'(0);
          shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
          if (n_q == NW'(DATA_BITS - 1)) begin
            n_d     = NW'(0);
            state_d = pen_q ? S_PARITY : S_STOP;
          end else begin
            n_d = n_q + NW'(1);
          end
        end else if (tick) begin
          s_d = s_q + SW'(1);
        end else begin
          s_d = s_q;
        end
      end
      S_PARITY: begin
        if (os_end) begin
          s_d     = SW'(0);
          state_d = S_STOP;
        end else if (tick) begin
          s_d = s_q + SW'(1);
        end else begin
          s_d = s_q;
        end
      end
      S_STOP: begin
        if (sb_end) begin
          s_d     = SW'(0);
          state_d = S_IDLE;
`ifdef UART_TX_BREAK_EN
          done_d   = ~in_brk_q;
          in_brk_d = 1'b0;
`else
          done_d  = 1'b1;
`endif
        end else if (tick) begin
          s_d = s_q + SW'(1);
        end else begin
          s_d = s_q;
        end
      end
`ifdef UART_TX_BREAK_EN
      S_BREAK: begin
        if (tick && (brk_q != BW'(FRAME_TICKS))) begin
          brk_d = brk_q + BW'(1);
        end else begin
          brk_d = brk_q;
        end
        if (!send_break && (brk_q == BW'(FRAME_TICKS))) begin
          state_d = S_STOP;
          s_d     = SW'(0);
        end else begin
          state_d = S_BREAK;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
        s_d     = SW'(0);
        n_d     = NW'(0);
      end
    endcase
  end

  // Output values registered alongside the state they belong to
  always_comb begin
    tx_d    = 1'b1;
    ready_d = 1'b0;
    busy_d  = 1'b1;
    case (state_d)
      S_IDLE: begin
        tx_d    = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_d;
      S_STOP:   tx_d = 1'b1;
      S_BREAK:  tx_d = 1'b0;
      default: begin
        tx_d    = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign tx           = tx_q;
  assign tx_ready     = ready_q;
  assign tx_busy      = busy_q;
  assign tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: scoreboard of queued frames checked cycle by cycle.
module tb_uart_tx_cfg;
  localparam int DB = 8;
  localparam int OS = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          tick;
  logic          tx_valid;
  logic [DB-1:0] tx_data_in;
  logic [1:0]    parity_mode;
  logic          tx_ready, tx, tx_busy, tx_done_tick;
  logic          tx_ready2, tx2, tx_busy2, tx_done_tick2;
`ifdef UART_TX_BREAK_EN
  logic          send_break;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int tick_div = 1;
  int tcnt = 0;

  typedef struct {
    logic [DB-1:0] data;
    logic [1:0]    mode;
  } frame_t;
  frame_t exp_q[$];

  always #5 clk = ~clk;

  uart_tx_cfg #(.DATA_BITS(DB), .OS_TICKS(OS), .SB_TICKS(16)) dut (
    .clk(clk), .reset(reset), .tick(tick), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_data_in(tx_data_in), .parity_mode(parity_mode),
`ifdef UART_TX_BREAK_EN
    .send_break(send_break),
`endif
    .tx(tx), .tx_busy(tx_busy), .tx_done_tick(tx_done_tick));

  uart_tx_cfg #(.DATA_BITS(DB), .OS_TICKS(OS), .SB_TICKS(32)) dut2 (
    .clk(clk), .reset(reset), .tick(tick), .tx_valid(tx_valid), .tx_ready(tx_ready2),
    .tx_data_in(tx_data_in), .parity_mode(parity_mode),
`ifdef UART_TX_BREAK_EN
    .send_break(send_break),
`endif
    .tx(tx2), .tx_busy(tx_busy2), .tx_done_tick(tx_done_tick2));

  // Tick generator: one tick every tick_div clocks
  initial begin
    tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tcnt = tcnt + 1;
      tick = ((tcnt % tick_div) == 0);
    end
  end

  function automatic int frame_len(input logic [1:0] m, input int sb);
    return OS * (1 + DB + (((m == 2'b01) || (m == 2'b10)) ? 1 : 0)) + sb;
  endfunction

  // Expected line level k clocks after the accept edge (tick every clock)
  function automatic logic exp_level(input frame_t f, input int k);
    int b;
    b = k / OS;
    if (b == 0) return 1'b0;
    if (b <= DB) return f.data[b-1];
    if (((f.mode == 2'b01) || (f.mode == 2'b10)) && (b == DB + 1))
      return (^f.data) ^ (f.mode == 2'b10);
    return 1'b1;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic start_frame(input logic [DB-1:0] d, input logic [1:0] m, input bit hold);
    frame_t f;
    int w;
    @(posedge clk);
    #1;
    tx_data_in  = d;
    parity_mode = m;
    tx_valid    = 1'b1;
    @(negedge clk);
    w = 0;
    while (tx_ready !== 1'b1 && w < 1000) begin
      @(negedge clk);
      w++;
    end
    n_tests++;
    if (tx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_wait: tx_ready=%b, required 1 within 1000 clk", tx_ready);
    end
    @(posedge clk);
    #1;
    if (!hold) tx_valid = 1'b0;
    f.data = d;
    f.mode = m;
    exp_q.push_back(f);
  endtask

  // Pop one expected frame and compare every clock of it, then the end-of-frame cycle
  task automatic rx_check(input string nm, input int sb);
    frame_t f;
    int L, bad_tx, bad_ctl;
    logic got_tx, want_tx;
    logic [2:0] got_ctl;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_queue: scoreboard empty, required 1 entry", nm);
      return;
    end
    f = exp_q.pop_front();
    L = frame_len(f.mode, sb);
    bad_tx = -1;
    bad_ctl = -1;
    got_tx = 1'b0;
    want_tx = 1'b0;
    got_ctl = 3'b000;
    for (int k = 0; k < L; k++) begin
      @(negedge clk);
      if (tx !== exp_level(f, k) && bad_tx < 0) begin
        bad_tx = k;
        got_tx = tx;
        want_tx = exp_level(f, k);
      end
      if ({tx_busy, tx_ready, tx_done_tick} !== 3'b100 && bad_ctl < 0) begin
        bad_ctl = k;
        got_ctl = {tx_busy, tx_ready, tx_done_tick};
      end
    end
    n_tests++;
    if (bad_tx >= 0) begin
      n_fail++;
      $display("FAIL %s_tx: clk %0d of frame tx=%b, required %b", nm, bad_tx, got_tx, want_tx);
    end
    n_tests++;
    if (bad_ctl >= 0) begin
      n_fail++;
      $display("FAIL %s_ctl: clk %0d busy/ready/done=%b, required 100", nm, bad_ctl, got_ctl);
    end
    @(negedge clk);
    n_tests++;
    if ({tx, tx_ready, tx_busy, tx_done_tick} !== 4'b1101) begin
      n_fail++;
      $display("FAIL %s_end: clk %0d tx/ready/busy/done=%b, required 1101", nm, L,
               {tx, tx_ready, tx_busy, tx_done_tick});
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tx_valid = 1'b0;
    tx_data_in = 8'h00;
    parity_mode = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b, required 1", tx); end
    n_tests++;
    if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b, required 1", tx_ready); end
    n_tests++;
    if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", tx_busy); end
    n_tests++;
    if (tx_done_tick !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b, required 0", tx_done_tick); end
    #1;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    start_frame(8'hA5, 2'b00, 1'b0);
    rx_check("basic_a5", 16);
  endtask

  task automatic test_parity();
    start_frame(8'h07, 2'b01, 1'b0);
    rx_check("even_07", 16);
    start_frame(8'h07, 2'b10, 1'b0);
    rx_check("odd_07", 16);
    start_frame(8'h07, 2'b11, 1'b0);
    rx_check("none11_07", 16);
    start_frame(8'h3A, 2'b10, 1'b0);
    rx_check("odd_3a", 16);
  endtask

  task automatic test_back_to_back();
    frame_t f;
    start_frame(8'h55, 2'b00, 1'b1);
    tx_data_in = 8'hAA;
    f.data = 8'hAA;
    f.mode = 2'b00;
    exp_q.push_back(f);
    rx_check("b2b_first", 16);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    rx_check("b2b_second", 16);
  endtask

  task automatic test_slow_stop2();
    frame_t f;
    logic lv[0:2047];
    int trans[$];
    int done_at, bad_len;
    logic prev;
    logic [DB-1:0] dec;
    do_reset();
    tick_div = 4;
    start_frame(8'h55, 2'b00, 1'b0);
    f = exp_q.pop_front();
    done_at = -1;
    prev = 1'b0;
    for (int k = 0; k < 2048; k++) begin
      @(negedge clk);
      lv[k] = tx2;
      if (tx2 !== prev) begin
        trans.push_back(k);
        prev = tx2;
      end
      if (tx_done_tick2 === 1'b1) begin
        done_at = k;
        break;
      end
    end
    n_tests++;
    if (trans.size() !== 9 || done_at < 0) begin
      n_fail++;
      $display("FAIL slow_shape: %0d transitions done_at=%0d, required 9 and a done pulse",
               trans.size(), done_at);
    end else begin
      n_tests++;
      if (trans[0] < 61 || trans[0] > 64) begin
        n_fail++;
        $display("FAIL slow_start_len: got %0d clk, required 61..64", trans[0]);
      end
      bad_len = 0;
      for (int i = 0; i < 8; i++)
        if (trans[i+1] - trans[i] !== 64) bad_len = trans[i+1] - trans[i];
      n_tests++;
      if (bad_len !== 0) begin
        n_fail++;
        $display("FAIL slow_bit_len: got %0d clk, required 64", bad_len);
      end
      for (int i = 0; i < DB; i++) dec[i] = lv[trans[0] + 64 * i + 32];
      n_tests++;
      if (dec !== f.data) begin
        n_fail++;
        $display("FAIL slow_data: got %h, required %h", dec, f.data);
      end
      n_tests++;
      if (done_at - trans[8] !== 128) begin
        n_fail++;
        $display("FAIL slow_stop_len: got %0d clk, required 128", done_at - trans[8]);
      end
    end
    repeat (8) @(posedge clk);
    tick_div = 1;
    do_reset();
  endtask

  task automatic test_reset_mid();
    frame_t f;
    int seen_done;
    start_frame(8'hFF, 2'b00, 1'b0);
    repeat (70) @(negedge clk);
    n_tests++;
    if ({tx, tx_busy} !== 2'b11) begin
      n_fail++;
      $display("FAIL mid_state: tx/busy=%b, required 11", {tx, tx_busy});
    end
    #1;
    reset = 1'b1;
    #1;
    n_tests++;
    if ({tx, tx_ready, tx_busy, tx_done_tick} !== 4'b1100) begin
      n_fail++;
      $display("FAIL mid_reset_out: tx/ready/busy/done=%b, required 1100",
               {tx, tx_ready, tx_busy, tx_done_tick});
    end
    f = exp_q.pop_front();
    seen_done = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (tx_done_tick !== 1'b0) seen_done++;
    end
    #1;
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (tx_done_tick !== 1'b0) seen_done++;
    end
    n_tests++;
    if (seen_done !== 0) begin
      n_fail++;
      $display("FAIL mid_no_done: %0d done pulses (abandoned frame 0x%h), required 0", seen_done, f.data);
    end
    start_frame(8'h3C, 2'b00, 1'b0);
    rx_check("after_reset_3c", 16);
  endtask

`ifdef UART_TX_BREAK_EN
  task automatic test_break();
    int lowc, highc, phase, seen_done;
    lowc = 0;
    highc = 0;
    phase = 0;
    seen_done = 0;
    fork
      begin
        @(posedge clk);
        #1;
        send_break = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        send_break = 1'b0;
      end
      begin
        for (int k = 0; k < 1000; k++) begin
          @(negedge clk);
          if (tx_done_tick !== 1'b0) seen_done++;
          if (phase == 0 && tx === 1'b0) phase = 1;
          if (phase == 1 && tx === 1'b1) phase = 2;
          if (phase == 1) lowc++;
          else if (phase == 2) begin
            if (tx_ready === 1'b1) break;
            highc++;
          end
        end
      end
    join
    n_tests++;
    if (lowc !== 200) begin n_fail++; $display("FAIL break_low: got %0d clk, required 200", lowc); end
    n_tests++;
    if (highc !== 16) begin n_fail++; $display("FAIL break_stop: got %0d clk, required 16", highc); end
    n_tests++;
    if (seen_done !== 0) begin n_fail++; $display("FAIL break_done: got %0d pulses, required 0", seen_done); end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef UART_TX_BREAK_EN
    send_break = 1'b0;
`endif
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_slow_stop2();
    test_reset_mid();
`ifdef UART_TX_BREAK_EN
    test_break();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
